// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: shared sizes and pointer helper for the FIFO stream reader.
package fifo_stream_reader_pkg;
    localparam int FRD_BUF_DEPTH = 3;
    localparam int FRD_PTR_W = 2;
    localparam int FRD_BURST_W = 16;

    function automatic logic [FRD_PTR_W-1:0] frd_ptr_inc(input logic [FRD_PTR_W-1:0] p);
        return (p == FRD_PTR_W'(FRD_BUF_DEPTH - 1)) ? '0 : p + 2'd1;
    endfunction
endpackage

// File: rtl/fifo_reader_skid_buf.sv
// fifo_reader_skid_buf: 3-entry circular buffer with push/pop, head/tail pointers and occupancy.
module fifo_reader_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     din,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head_data,
    output logic [FRD_PTR_W-1:0] occ
);
    logic [WIDTH-1:0]     mem [FRD_BUF_DEPTH];
    logic [FRD_PTR_W-1:0] head, tail;

    // Entries are cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem  <= '{default: '0};
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= din;
                tail      <= frd_ptr_inc(tail);
            end
            if (pop) head <= frd_ptr_inc(head);
            occ <= occ + FRD_PTR_W'(push) - FRD_PTR_W'(pop);
        end
    end

    assign head_data = mem[head];
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a 1-cycle-latency FIFO read port into a valid/ready stream.
// Optional FIFO_READER_LAST_EN adds burst_len / m_last burst framing.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   fifo_re,
    input  logic [WIDTH-1:0]       fifo_dout,
    input  logic                   fifo_empty,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data
`ifdef FIFO_READER_LAST_EN
    ,
    input  logic [FRD_BURST_W-1:0] burst_len,
    output logic                   m_last
`endif
);
`ifdef FIFO_READER_LAST_EN
    localparam int BW = WIDTH + 1;
`else
    localparam int BW = WIDTH;
`endif

    logic                 inflight;
    logic                 pop;
    logic [FRD_PTR_W-1:0] occ;
    logic [BW-1:0]        din, head;

    // Credit counts words already buffered plus the one still coming back from the FIFO.
    assign fifo_re = !reset && !fifo_empty &&
                     (({1'b0, occ} + {2'b0, inflight}) < 3'(FRD_BUF_DEPTH));
    assign m_valid = (occ != '0);
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (reset) inflight <= 1'b0;
        else       inflight <= fifo_re;
    end

`ifdef FIFO_READER_LAST_EN
    logic [FRD_BURST_W-1:0] cnt, eff_len, new_len, cur_len;
    logic                   last_in;

    // Framing is decided as each word enters the buffer; order is preserved so it
    // matches the word's position at pop time.
    assign new_len = (burst_len == '0) ? FRD_BURST_W'(1) : burst_len;
    assign cur_len = (cnt == '0) ? new_len : eff_len;
    assign last_in = (cnt + 1'b1) == cur_len;
    assign din     = {last_in, fifo_dout};
    assign {m_last, m_data} = head;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            eff_len <= '0;
        end else if (inflight) begin
            eff_len <= cur_len;
            cnt     <= last_in ? '0 : cnt + 1'b1;
        end
    end
`else
    assign din    = fifo_dout;
    assign m_data = head;
`endif

    fifo_reader_skid_buf #(.WIDTH(BW)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .din       (din),
        .pop       (pop),
        .head_data (head),
        .occ       (occ)
    );
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed and randomized checks of fifo_stream_reader against a FIFO model.
module tb_fifo_stream_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_re;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
`ifdef FIFO_READER_LAST_EN
    logic [15:0] burst_len = 16'd4;
    logic        m_last;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    // Upstream FIFO model: dout valid the cycle after an accepted read, shared reset.
    logic [31:0] fmem [0:4095];
    int wr = 0;
    int rd = 0;
    assign fifo_empty = (wr == rd);

    always @(posedge clk) begin
        if (reset) rd <= wr;
        else if (fifo_re) begin
            fifo_dout <= fmem[rd % 4096];
            rd        <= rd + 1;
        end
    end

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_re    (fifo_re),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_READER_LAST_EN
        ,
        .burst_len  (burst_len),
        .m_last     (m_last)
`endif
    );

    task automatic push(input logic [31:0] v);
        fmem[wr % 4096] = v;
        wr = wr + 1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        push(32'h55);
        #1;
        n_cmp++;
        if (fifo_re !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_re: fifo_re=%b want 0", fifo_re);
        end
        @(negedge clk);
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: m_valid=%b want 0", m_valid);
        end
        n_cmp++;
        if (m_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: m_data=%h want 0", m_data);
        end
`ifdef FIFO_READER_LAST_EN
        n_cmp++;
        if (m_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_last: m_last=%b want 0", m_last);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_latency;
        logic        ev [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ed [5] = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
        do_reset();
        push(32'h11);
        push(32'h22);
        push(32'h33);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (m_valid !== ev[i]) begin
                n_fail++;
                $display("FAIL latency_valid[%0d]: m_valid=%b want %b", i, m_valid, ev[i]);
            end else if (ev[i]) begin
                n_cmp++;
                if (m_data !== ed[i]) begin
                    n_fail++;
                    $display("FAIL latency_data[%0d]: m_data=%h want %h", i, m_data, ed[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int  pulses = 0;
        int  got = 0;
        bit  gap = 0;
        do_reset();
        for (int i = 0; i < 8; i++) push(32'h101 + i);
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (fifo_re) pulses++;
            @(negedge clk);
        end
        n_cmp++;
        if (pulses !== 3) begin
            n_fail++;
            $display("FAIL bp_re_pulses: got %0d want 3", pulses);
        end
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 32'h101) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b data=%h want 1/101", m_valid, m_data);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (m_valid) begin
                n_cmp++;
                if (m_data !== 32'h101 + got) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d]: m_data=%h want %h", got, m_data, 32'h101 + got);
                end
                got++;
            end else if (got > 0 && got < 8) gap = 1;
            @(negedge clk);
        end
        n_cmp++;
        if (got !== 8 || gap) begin
            n_fail++;
            $display("FAIL bp_drain: words=%0d gap=%0d want 8/0", got, gap);
        end
    endtask

    task automatic test_reset_mid;
        int got = 0;
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(32'h200 + i);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (m_valid !== 1'b0 || m_data !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_clear: valid=%b data=%h want 0/0", m_valid, m_data);
        end
        reset = 1'b0;
        push(32'hA1);
        push(32'hA2);
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (m_valid) begin
                n_cmp++;
                if (m_data !== 32'hA1 + got) begin
                    n_fail++;
                    $display("FAIL midreset_order[%0d]: m_data=%h want %h", got, m_data, 32'hA1 + got);
                end
                got++;
            end
        end
        n_cmp++;
        if (got !== 2) begin
            n_fail++;
            $display("FAIL midreset_count: words=%0d want 2", got);
        end
    endtask

    task automatic test_random;
        logic [31:0] sb [$];
        logic [31:0] v;
        int pushed = 0;
        int got = 0;
        int viol = 0;
        do_reset();
        for (int c = 0; c < 20000 && got < 1000; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (pushed < 1000 && $urandom_range(0, 2) != 0) begin
                v = $urandom;
                push(v);
                sb.push_back(v);
                pushed++;
            end
            #1;
            if (fifo_re && fifo_empty) viol++;
            if (m_valid && m_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: m_data=%h want no word", m_data);
                end else begin
                    v = sb.pop_front();
                    if (m_data !== v) begin
                        n_fail++;
                        $display("FAIL rand_order[%0d]: m_data=%h want %h", got, m_data, v);
                    end
                end
                got++;
            end
            @(negedge clk);
        end
        m_ready = 1'b0;
        n_cmp++;
        if (got !== 1000) begin
            n_fail++;
            $display("FAIL rand_count: words=%0d want 1000", got);
        end
        n_cmp++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL rand_re_empty: violations=%0d want 0", viol);
        end
    endtask

    task automatic test_toggle;
        int pushed = 0;
        int got = 0;
        do_reset();
        m_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (pushed < 20 && c % 2 == 0) begin
                push(32'h300 + pushed);
                pushed++;
            end
            #1;
            if (m_valid) begin
                n_cmp++;
                if (m_data !== 32'h300 + got) begin
                    n_fail++;
                    $display("FAIL toggle_order[%0d]: m_data=%h want %h", got, m_data, 32'h300 + got);
                end
                got++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (got !== 20) begin
            n_fail++;
            $display("FAIL toggle_count: words=%0d want 20", got);
        end
    endtask

`ifdef FIFO_READER_LAST_EN
    task automatic test_last;
        int got = 0;
        logic want;
        burst_len = 16'd4;
        do_reset();
        for (int i = 0; i < 10; i++) push(32'h400 + i);
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m_valid) begin
                want = (got == 3 || got == 7);
                n_cmp++;
                if (m_last !== want) begin
                    n_fail++;
                    $display("FAIL last4[%0d]: m_last=%b want %b", got, m_last, want);
                end
                got++;
            end
            @(negedge clk);
        end
        burst_len = 16'd0;
        do_reset();
        got = 0;
        for (int i = 0; i < 4; i++) push(32'h500 + i);
        m_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (m_valid) begin
                n_cmp++;
                if (m_last !== 1'b1) begin
                    n_fail++;
                    $display("FAIL last0[%0d]: m_last=%b want 1", got, m_last);
                end
                got++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (got !== 4) begin
            n_fail++;
            $display("FAIL last0_count: words=%0d want 4", got);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_latency();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_toggle();
`ifdef FIFO_READER_LAST_EN
        test_last();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
